// File: rtl/puzzle_loader.sv
// Puzzle source: picks a pseudo-random, non-repeating map for the requested level from a flat
// bank and copies it row by row into registered solution/visibility outputs.
module puzzle_loader #(
  parameter int unsigned NUM_LEVELS     = 2,
  parameter int unsigned MAPS_PER_LEVEL = 8,
  parameter int unsigned ROWS           = 9,
  parameter int unsigned COLS           = 9,
  parameter int unsigned CELL_BITS      = 4,
  parameter int unsigned VIS_BITS       = 2,
  localparam int unsigned LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int unsigned IDX_W  = $clog2(MAPS_PER_LEVEL),
  localparam int unsigned ROW_M  = COLS * CELL_BITS,
  localparam int unsigned ROW_V  = COLS * VIS_BITS,
  localparam int unsigned MAP_W  = ROWS * ROW_M,
  localparam int unsigned VIS_W  = ROWS * ROW_V,
  localparam int unsigned BANK_M = NUM_LEVELS * MAPS_PER_LEVEL * MAP_W,
  localparam int unsigned BANK_V = NUM_LEVELS * MAPS_PER_LEVEL * VIS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic [LVL_W-1:0]  difficulty,
  input  logic [BANK_M-1:0] maps_flat,
  input  logic [BANK_V-1:0] vis_flat,
  output logic [MAP_W-1:0]  selected_map,
  output logic [VIS_W-1:0]  selected_visibility,
  output logic [IDX_W-1:0]  map_index,
  output logic [LVL_W-1:0]  map_level,
  output logic              busy,
  output logic              valid,
  output logic              load_done
);

  localparam int unsigned ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned SRC_M_W = $clog2(BANK_M);
  localparam int unsigned SRC_V_W = $clog2(BANK_V);
  localparam int unsigned DST_M_W = $clog2(MAP_W);
  localparam int unsigned DST_V_W = $clog2(VIS_W);

  typedef enum logic [1:0] {StIdle, StPick, StCopy, StDone} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [15:0]          r_lfsr;
  logic                 w_lfsr_fb;
  logic [LVL_W-1:0]     r_lvl;
  logic [LVL_W-1:0]     w_lvl_clamp;
  logic [ROW_W-1:0]     r_row;
  logic [IDX_W-1:0]     r_last_idx [NUM_LEVELS];
  logic [NUM_LEVELS-1:0] r_last_valid;
  logic [IDX_W-1:0]     w_cand_raw;
  logic [IDX_W-1:0]     w_cand;
  logic                 w_hit;

  logic [MAP_W-1:0]     r_sel_map;
  logic [VIS_W-1:0]     r_sel_vis;
  logic [IDX_W-1:0]     r_map_index;
  logic [LVL_W-1:0]     r_map_level;
  logic                 r_busy;
  logic                 r_valid;
  logic                 r_load_done;

  logic [SRC_M_W-1:0]   w_src_m;
  logic [SRC_V_W-1:0]   w_src_v;
  logic [DST_M_W-1:0]   w_dst_m;
  logic [DST_V_W-1:0]   w_dst_v;
  logic [MAP_W-1:0]     w_map_next;
  logic [VIS_W-1:0]     w_vis_next;

  // Taps x^16+x^14+x^13+x^11+1, shifted left with feedback into bit 0.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_lvl_clamp = (32'(difficulty) > NUM_LEVELS - 1) ? LVL_W'(NUM_LEVELS - 1) : difficulty;

  // A pick equal to the level's previous one is bumped to the next index, wrapping.
  always_comb begin
    w_cand_raw = r_lfsr[IDX_W-1:0];
    w_hit      = r_last_valid[r_lvl] && (w_cand_raw == r_last_idx[r_lvl]);
    w_cand     = w_hit ? w_cand_raw + IDX_W'(1) : w_cand_raw;
  end

  always_comb begin
    w_src_m = SRC_M_W'((32'(r_map_level) * MAPS_PER_LEVEL + 32'(r_map_index)) * MAP_W
                       + 32'(r_row) * ROW_M);
    w_src_v = SRC_V_W'((32'(r_map_level) * MAPS_PER_LEVEL + 32'(r_map_index)) * VIS_W
                       + 32'(r_row) * ROW_V);
    w_dst_m = DST_M_W'(32'(r_row) * ROW_M);
    w_dst_v = DST_V_W'(32'(r_row) * ROW_V);
    w_map_next = r_sel_map;
    w_vis_next = r_sel_vis;
    w_map_next[w_dst_m +: ROW_M] = maps_flat[w_src_m +: ROW_M];
    w_vis_next[w_dst_v +: ROW_V] = vis_flat[w_src_v +: ROW_V];
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (load_req) w_state_next = StPick;
      StPick:  w_state_next = StCopy;
      StCopy:  if (r_row == ROW_W'(ROWS - 1)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StIdle;
      r_lfsr       <= 16'hACE1;
      r_lvl        <= '0;
      r_row        <= '0;
      r_last_valid <= '0;
      for (int l = 0; l < NUM_LEVELS; l++) r_last_idx[l] <= '0;
      r_sel_map    <= '0;
      r_sel_vis    <= '0;
      r_map_index  <= '0;
      r_map_level  <= '0;
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
      r_state     <= w_state_next;
      r_load_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (load_req) begin
            r_lvl  <= w_lvl_clamp;
            r_busy <= 1'b1;
          end
        end
        StPick: begin
          r_map_index         <= w_cand;
          r_map_level         <= r_lvl;
          r_last_idx[r_lvl]   <= w_cand;
          r_last_valid[r_lvl] <= 1'b1;
          r_valid             <= 1'b0;
          r_sel_map           <= '0;
          r_sel_vis           <= '0;
          r_row               <= '0;
        end
        StCopy: begin
          r_sel_map <= w_map_next;
          r_sel_vis <= w_vis_next;
          r_row     <= r_row + ROW_W'(1);
        end
        StDone: begin
          r_valid     <= 1'b1;
          r_load_done <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign selected_map        = r_sel_map;
  assign selected_visibility = r_sel_vis;
  assign map_index           = r_map_index;
  assign map_level           = r_map_level;
  assign busy                = r_busy;
  assign valid               = r_valid;
  assign load_done           = r_load_done;

endmodule

// File: tb/tb_puzzle_loader.sv
// Scoreboard bench for puzzle_loader: stimulus pushes predicted picks, a monitor checks each
// completed load against the bank and the expected timing.
module tb_puzzle_loader;

  localparam int NL = 3;
  localparam int MP = 8;
  localparam int RW = 9;
  localparam int CL = 9;
  localparam int CB = 4;
  localparam int VB = 2;
  localparam int LW = 2;
  localparam int IW = 3;
  localparam int ROW_M = CL * CB;
  localparam int ROW_V = CL * VB;
  localparam int MAP_W = RW * ROW_M;
  localparam int VIS_W = RW * ROW_V;
  localparam int BANK_M = NL * MP * MAP_W;
  localparam int BANK_V = NL * MP * VIS_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              load_req;
  logic [LW-1:0]     difficulty;
  logic [BANK_M-1:0] maps_flat;
  logic [BANK_V-1:0] vis_flat;
  logic [MAP_W-1:0]  selected_map;
  logic [VIS_W-1:0]  selected_visibility;
  logic [IW-1:0]     map_index;
  logic [LW-1:0]     map_level;
  logic              busy;
  logic              valid;
  logic              load_done;

  puzzle_loader #(
    .NUM_LEVELS    (NL),
    .MAPS_PER_LEVEL(MP),
    .ROWS          (RW),
    .COLS          (CL),
    .CELL_BITS     (CB),
    .VIS_BITS      (VB)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .load_req           (load_req),
    .difficulty         (difficulty),
    .maps_flat          (maps_flat),
    .vis_flat           (vis_flat),
    .selected_map       (selected_map),
    .selected_visibility(selected_visibility),
    .map_index          (map_index),
    .map_level          (map_level),
    .busy               (busy),
    .valid              (valid),
    .load_done          (load_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [LW-1:0] lvl;
    int            due;
  } exp_t;

  exp_t          q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [15:0]   m_lfsr;
  int            cyc;
  logic [IW-1:0] last_idx [NL];
  logic          last_valid [NL];

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic logic [MAP_W-1:0] bank_map(input int l, input int i);
    return maps_flat[(l * MP + i) * MAP_W +: MAP_W];
  endfunction

  function automatic logic [VIS_W-1:0] bank_vis(input int l, input int i);
    return vis_flat[(l * MP + i) * VIS_W +: VIS_W];
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference LFSR and cycle count, both cleared by the same reset as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr <= 16'hACE1;
      cyc    <= 0;
    end else begin
      m_lfsr <= lfsr_step(m_lfsr);
      cyc    <= cyc + 1;
    end
  end

  // Monitor: checks every completed load and the busy window length.
  int            busy_cnt = 0;
  logic [IW-1:0] prev1;
  logic          prev1_ok = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
      prev1_ok = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      else if (busy_cnt != 0) begin
        check("busy_len", busy_cnt, RW + 2);
        busy_cnt = 0;
      end
      if (load_done) begin
        if (q.size() == 0) check("unexpected_done", load_done, 0);
        else begin
          e = q.pop_front();
          check("map_index", map_index, e.idx);
          check("map_level", map_level, e.lvl);
          check("selected_map", selected_map, bank_map(int'(e.lvl), int'(e.idx)));
          check("selected_vis", selected_visibility, bank_vis(int'(e.lvl), int'(e.idx)));
          check("valid_at_done", valid, 1);
          check("done_cycle", cyc, e.due);
          if (e.lvl == 2'd1) begin
            if (prev1_ok) check("no_repeat", map_index == prev1, 0);
            prev1    = map_index;
            prev1_ok = 1'b1;
          end
        end
      end
    end
  end

  // Call at a negedge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue_now(input logic [LW-1:0] d, output logic [IW-1:0] idx);
    logic [LW-1:0] lvl;
    logic [IW-1:0] cand;
    exp_t          e;
    load_req   = 1'b1;
    difficulty = d;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    lvl  = (d > LW'(NL - 1)) ? LW'(NL - 1) : d;
    cand = m_lfsr[IW-1:0];
    if (last_valid[lvl] && cand == last_idx[lvl]) cand = cand + IW'(1);
    last_idx[lvl]   = cand;
    last_valid[lvl] = 1'b1;
    e.idx = cand;
    e.lvl = lvl;
    e.due = cyc + RW + 2;
    q.push_back(e);
    idx = cand;
  endtask

  task automatic issue(input logic [LW-1:0] d, output logic [IW-1:0] idx);
    @(negedge clk);
    issue_now(d, idx);
  endtask

  task automatic load(input logic [LW-1:0] d, output logic [IW-1:0] idx);
    issue(d, idx);
    repeat (RW + 2) @(posedge clk);
  endtask

  task automatic clear_model();
    for (int l = 0; l < NL; l++) begin
      last_idx[l]   = '0;
      last_valid[l] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [IW-1:0]    idx;
    logic [MAP_W-1:0] em;
    logic [VIS_W-1:0] ev;
    logic [15:0]      nxt;
    logic             found;

    reset      = 1'b1;
    load_req   = 1'b0;
    difficulty = '0;
    for (int b = 0; b < BANK_M; b++) maps_flat[b] = 1'($urandom_range(0, 1));
    for (int b = 0; b < BANK_V; b++) vis_flat[b] = 1'($urandom_range(0, 1));
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_map", selected_map, 0);
    check("rst_vis", selected_visibility, 0);
    check("rst_index", map_index, 0);
    check("rst_level", map_level, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_done", load_done, 0);

    // Single load at level 0 with a look at the partially copied board.
    issue(2'd0, idx);
    repeat (5) @(posedge clk);
    #1;
    em = bank_map(0, int'(idx));
    ev = bank_vis(0, int'(idx));
    check("midcopy_map_lo", selected_map[4*ROW_M-1:0], em[4*ROW_M-1:0]);
    check("midcopy_map_hi", selected_map[MAP_W-1:4*ROW_M], 0);
    check("midcopy_vis_lo", selected_visibility[4*ROW_V-1:0], ev[4*ROW_V-1:0]);
    check("midcopy_vis_hi", selected_visibility[VIS_W-1:4*ROW_V], 0);
    repeat (RW + 2 - 5) @(posedge clk);
    @(negedge clk);
    check("valid_hold", valid, 1);

    for (int k = 0; k < 64; k++) load(2'd1, idx);

    // Drive level 1 until its history is 7, then align the LFSR so the raw pick collides.
    for (int k = 0; k < 200 && !(last_valid[1] && last_idx[1] == 3'd7); k++) load(2'd1, idx);
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      nxt = lfsr_step(m_lfsr);
      if (nxt[IW-1:0] == 3'd7) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("collision_align", found, 1);
    issue_now(2'd1, idx);
    repeat (RW + 2) @(posedge clk);
    @(negedge clk);
    check("collision_wrap", map_index, 0);

    load(2'd0, idx);
    load(2'd1, idx);
    load(2'd0, idx);
    load(2'd1, idx);
    load(2'd2, idx);
    load(2'd3, idx);
    @(negedge clk);
    check("clamp_level", map_level, 2);

    // Requests in PICK and at COPY row 4 must be ignored.
    issue(2'd0, idx);
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    repeat (30) @(negedge clk);
    check("busy_idle_after", busy, 0);

    // Asynchronous reset while row 5 is being copied.
    issue(2'd1, idx);
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_map", selected_map, 0);
    check("arst_vis", selected_visibility, 0);
    check("arst_index", map_index, 0);
    check("arst_level", map_level, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", valid, 0);
    check("arst_done", load_done, 0);
    q.delete();
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    load(2'd1, idx);
    load(2'd1, idx);

    repeat (20) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
